// File: rtl/tdu_pkg.sv
// Shared opcodes, station/register tags and common-data-bus types for the Tomasulo dispatch unit.
package tdu_pkg;

  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;
  localparam int BUS_W  = TAG_W + DATA_W;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_MULTI = 8'h04;

  // Tag 0 is reserved to mean "data valid / bus idle".
  localparam logic [TAG_W-1:0] TAG_R0  = 8'h10;
  localparam logic [TAG_W-1:0] TAG_R1  = 8'h11;
  localparam logic [TAG_W-1:0] TAG_R2  = 8'h12;
  localparam logic [TAG_W-1:0] TAG_R3  = 8'h13;
  localparam logic [TAG_W-1:0] TAG_A0  = 8'h20;
  localparam logic [TAG_W-1:0] TAG_A1  = 8'h21;
  localparam logic [TAG_W-1:0] TAG_A2  = 8'h22;
  localparam logic [TAG_W-1:0] TAG_M0  = 8'h30;
  localparam logic [TAG_W-1:0] TAG_M1  = 8'h31;
  localparam logic [TAG_W-1:0] TAG_LD0 = 8'h40;
  localparam logic [TAG_W-1:0] TAG_LD1 = 8'h41;
  localparam logic [TAG_W-1:0] TAG_ST0 = 8'h50;
  localparam logic [TAG_W-1:0] TAG_ST1 = 8'h51;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } rs_state_t;

  // Resolve one operand against the three buses; load wins over mult wins over add.
  function automatic cdb_t cdb_snoop(input cdb_t opnd, input cdb_t load_cdb,
                                     input cdb_t mult_cdb, input cdb_t add_cdb);
    cdb_t res;
    res = opnd;
    if (opnd.tag != '0) begin
      if (load_cdb.tag == opnd.tag) begin
        res.tag  = '0;
        res.data = load_cdb.data;
      end else if (mult_cdb.tag == opnd.tag) begin
        res.tag  = '0;
        res.data = mult_cdb.data;
      end else if (add_cdb.tag == opnd.tag) begin
        res.tag  = '0;
        res.data = add_cdb.data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: lifecycle state, two operand slots and snooping of the three CDBs.
module rs_entry
  import tdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              alloc_issue,
  input  cdb_t              alloc_src1,
  input  cdb_t              alloc_src2,
  input  logic              issue,
  input  logic              retire,
  input  cdb_t              loadbus,
  input  cdb_t              multbus,
  input  cdb_t              addbus,
  output rs_state_t         state,
  output logic [DATA_W-1:0] src1_data,
  output logic [DATA_W-1:0] src2_data
);

  rs_state_t state_q, state_d;
  cdb_t      src1_q, src1_d;
  cdb_t      src2_q, src2_d;
  cdb_t      snoop1, snoop2;

  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    snoop1  = cdb_snoop(src1_q, loadbus, multbus, addbus);
    snoop2  = cdb_snoop(src2_q, loadbus, multbus, addbus);
    case (state_q)
      FREE: begin
        if (alloc) begin
          // Operands arrive already resolved against this cycle's buses.
          src1_d = alloc_src1;
          src2_d = alloc_src2;
          if (alloc_issue) begin
            state_d = EXEC;
          end else if (alloc_src1.tag == '0 && alloc_src2.tag == '0) begin
            state_d = READY;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        src1_d = snoop1;
        src2_d = snoop2;
        if (snoop1.tag == '0 && snoop2.tag == '0) begin
          state_d = READY;
        end
      end
      READY: begin
        if (issue) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      src1_q  <= '0;
      src2_q  <= '0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
    end
  end

  assign state     = state_q;
  assign src1_data = src1_q.data;
  assign src2_data = src2_q.data;

endmodule

// File: rtl/add_reservation_station.sv
// ADD reservation station with allocation/issue priority encoders and an ADD_LAT-deep adder pipeline.
// Optional RS_BYPASS_EN: a fully-resolved ADD may issue in its own dispatch cycle when nothing older is READY.
module add_reservation_station
  import tdu_pkg::*;
#(
  parameter int               RS_DEPTH = 3,
  parameter logic [TAG_W-1:0] TAG_BASE = 8'h20,
  parameter int               ADD_LAT  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  input  logic [7:0]       disp_op,
  input  logic [BUS_W-1:0] disp_src1,
  input  logic [BUS_W-1:0] disp_src2,
  output logic             disp_ready,
  output logic [TAG_W-1:0] disp_tag,
  input  logic [BUS_W-1:0] loadbus,
  input  logic [BUS_W-1:0] multbus,
  output logic [BUS_W-1:0] addbus
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  cdb_t              load_cdb, mult_cdb, add_cdb;
  cdb_t              alloc_src1, alloc_src2;
  rs_state_t         ent_state [RS_DEPTH];
  logic [DATA_W-1:0] ent_src1  [RS_DEPTH];
  logic [DATA_W-1:0] ent_src2  [RS_DEPTH];

  logic              free_found, ready_found;
  logic [IDX_W-1:0]  free_idx, ready_idx;
  logic              accept, bypass;
  logic [RS_DEPTH-1:0] alloc_vec, issue_vec, retire_vec;

  logic              iss_valid;
  logic [TAG_W-1:0]  iss_tag;
  logic [DATA_W-1:0] iss_sum;
  cdb_t              pipe_q [ADD_LAT];
  cdb_t              pipe_d [ADD_LAT];

  assign load_cdb = loadbus;
  assign mult_cdb = multbus;
  assign add_cdb  = pipe_q[ADD_LAT-1];
  assign addbus   = add_cdb;

  // Lowest-index FREE entry for allocation and lowest-index READY entry for issue.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!free_found && ent_state[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!ready_found && ent_state[i] == READY) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_found;
  assign disp_tag   = free_found ? (TAG_BASE + TAG_W'(free_idx)) : '0;
  assign accept     = disp_valid && free_found && (disp_op == OP_ADD);

  // Capture same-cycle broadcasts so a new entry never waits on a tag already gone by.
  assign alloc_src1 = cdb_snoop(cdb_t'(disp_src1), load_cdb, mult_cdb, add_cdb);
  assign alloc_src2 = cdb_snoop(cdb_t'(disp_src2), load_cdb, mult_cdb, add_cdb);

`ifdef RS_BYPASS_EN
  assign bypass = accept && !ready_found && (alloc_src1.tag == '0) && (alloc_src2.tag == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    alloc_vec  = '0;
    issue_vec  = '0;
    retire_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      alloc_vec[i]  = accept && (free_idx == IDX_W'(i));
      issue_vec[i]  = ready_found && (ready_idx == IDX_W'(i));
      retire_vec[i] = (add_cdb.tag == (TAG_BASE + TAG_W'(i)));
    end
  end

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_entry
    rs_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (alloc_vec[g]),
      .alloc_issue(bypass),
      .alloc_src1 (alloc_src1),
      .alloc_src2 (alloc_src2),
      .issue      (issue_vec[g]),
      .retire     (retire_vec[g]),
      .loadbus    (load_cdb),
      .multbus    (mult_cdb),
      .addbus     (add_cdb),
      .state      (ent_state[g]),
      .src1_data  (ent_src1[g]),
      .src2_data  (ent_src2[g])
    );
  end

  // A waiting READY entry always takes the adder ahead of a bypassing newcomer.
  always_comb begin
    iss_valid = ready_found || bypass;
    iss_tag   = '0;
    iss_sum   = '0;
    if (ready_found) begin
      iss_tag = TAG_BASE + TAG_W'(ready_idx);
      iss_sum = ent_src1[ready_idx] + ent_src2[ready_idx];
    end else if (bypass) begin
      iss_tag = TAG_BASE + TAG_W'(free_idx);
      iss_sum = alloc_src1.data + alloc_src2.data;
    end
  end

  always_comb begin
    pipe_d[0] = '0;
    if (iss_valid) begin
      pipe_d[0].tag  = iss_tag;
      pipe_d[0].data = iss_sum;
    end
    for (int k = 1; k < ADD_LAT; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ADD_LAT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ADD_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

endmodule

// File: tb/tb_add_reservation_station.sv
// Bench for add_reservation_station: directed vector table, hand sequences and random traffic
// checked every cycle against a cycle-count/scoreboard model of the station.
`timescale 1ns/1ps
module tb_add_reservation_station;
  import tdu_pkg::*;

  localparam int LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        disp_valid;
  logic [7:0]  disp_op;
  logic [39:0] disp_src1, disp_src2, loadbus, multbus;
  logic        disp_ready;
  logic [7:0]  disp_tag;
  logic [39:0] addbus;

  add_reservation_station #(.RS_DEPTH(3), .TAG_BASE(8'h20), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_ready(disp_ready),
    .disp_tag(disp_tag), .loadbus(loadbus), .multbus(multbus), .addbus(addbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: per-entry occupancy plus a result schedule keyed by cycle number.
  bit          m_busy   [3];
  bit          m_issued [3];
  int          m_free_at[3];
  logic [39:0] m_op1    [3];
  logic [39:0] m_op2    [3];
  logic [39:0] m_sched  [int];
  int          cyc = 0;

  logic        seen_ready;
  logic [7:0]  seen_tag;
  logic [39:0] seen_bus;
  int          res_cyc[$];
  logic [39:0] res_val[$];

  typedef struct {
    logic        dv;
    logic [7:0]  op;
    logic [39:0] s1, s2, lb, mb;
    logic        exp_ready;
    logic [7:0]  exp_tag;
    logic [39:0] exp_bus;
    string       name;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic dv, input logic [7:0] op, input logic [39:0] s1,
                              input logic [39:0] s2, input logic [39:0] lb, input logic [39:0] mb,
                              input logic er, input logic [7:0] et, input logic [39:0] eb,
                              input string name);
    vec_t v;
    v.dv = dv; v.op = op; v.s1 = s1; v.s2 = s2; v.lb = lb; v.mb = mb;
    v.exp_ready = er; v.exp_tag = et; v.exp_bus = eb; v.name = name;
    return v;
  endfunction

  function automatic logic [39:0] resolve(input logic [39:0] opnd, input logic [39:0] lb,
                                          input logic [39:0] mb, input logic [39:0] ab);
    if (opnd[39:32] == 8'h00) return opnd;
    if (lb[39:32] == opnd[39:32]) return {8'h00, lb[31:0]};
    if (mb[39:32] == opnd[39:32]) return {8'h00, mb[31:0]};
    if (ab[39:32] == opnd[39:32]) return {8'h00, ab[31:0]};
    return opnd;
  endfunction

  function automatic logic [39:0] rand_opnd();
    logic [7:0] t;
    case ($urandom_range(0, 9))
      0: t = 8'h30;
      1: t = 8'h31;
      2: t = 8'h40;
      3: t = 8'h41;
      default: t = 8'h00;
    endcase
    return {t, 32'($urandom)};
  endfunction

  task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] model_bus();
    return m_sched.exists(cyc) ? m_sched[cyc] : 40'h0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_issued[i] = 1'b0;
    end
    m_sched.delete();
  endtask

  task automatic modelIssue(input int idx);
    m_issued[idx]  = 1'b1;
    m_sched[cyc + LAT] = {8'(32'h20 + idx), 32'(m_op1[idx][31:0] + m_op2[idx][31:0])};
    m_free_at[idx] = cyc + LAT + 1;
  endtask

  task automatic modelStep(input logic dv, input logic [7:0] op, input logic [39:0] s1,
                           input logic [39:0] s2, input logic [39:0] lb, input logic [39:0] mb);
    logic [39:0] ab;
    logic [39:0] n1, n2;
    int iss;
    int fi;
    ab  = model_bus();
    iss = -1;
    fi  = -1;
    for (int i = 0; i < 3; i++) begin
      if (iss < 0 && m_busy[i] && !m_issued[i] && m_op1[i][39:32] == 8'h00 && m_op2[i][39:32] == 8'h00)
        iss = i;
      if (fi < 0 && !m_busy[i]) fi = i;
    end
    n1 = resolve(s1, lb, mb, ab);
    n2 = resolve(s2, lb, mb, ab);
    if (iss >= 0) modelIssue(iss);
    for (int i = 0; i < 3; i++) begin
      if (m_busy[i] && !m_issued[i]) begin
        m_op1[i] = resolve(m_op1[i], lb, mb, ab);
        m_op2[i] = resolve(m_op2[i], lb, mb, ab);
      end
    end
    if (dv && op == OP_ADD && fi >= 0) begin
      m_busy[fi]   = 1'b1;
      m_issued[fi] = 1'b0;
      m_op1[fi]    = n1;
      m_op2[fi]    = n2;
`ifdef RS_BYPASS_EN
      if (iss < 0 && n1[39:32] == 8'h00 && n2[39:32] == 8'h00) modelIssue(fi);
`endif
    end
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (m_busy[i] && m_issued[i] && m_free_at[i] <= cyc) m_busy[i] = 1'b0;
    end
  endtask

  task automatic checkOutput();
    int fi;
    fi = -1;
    for (int i = 0; i < 3; i++) if (fi < 0 && !m_busy[i]) fi = i;
    seen_ready = disp_ready;
    seen_tag   = disp_tag;
    seen_bus   = addbus;
    if (addbus != 40'h0) begin
      res_cyc.push_back(cyc);
      res_val.push_back(addbus);
    end
    compareVal("model_ready", disp_ready, fi >= 0);
    compareVal("model_tag", disp_tag, (fi >= 0) ? 8'(32'h20 + fi) : 8'h00);
    compareVal("model_addbus", addbus, model_bus());
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] op, input logic [39:0] s1,
                               input logic [39:0] s2, input logic [39:0] lb, input logic [39:0] mb);
    @(negedge clk);
    disp_valid = dv; disp_op = op; disp_src1 = s1; disp_src2 = s2;
    loadbus = lb; multbus = mb;
    #1;
    checkOutput();
    modelStep(dv, op, s1, s2, lb, mb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 40'h0, 40'h0, 40'h0, 40'h0);
  endtask

  task automatic doReset();
    #1;
    rst_n = 1'b0;
    disp_valid = 1'b0; disp_op = 8'h00; disp_src1 = '0; disp_src2 = '0;
    loadbus = '0; multbus = '0;
    modelReset();
    #1;
    compareVal("reset_addbus_async", addbus, 40'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      compareVal("reset_addbus", addbus, 40'h0);
      compareVal("reset_ready", disp_ready, 1'b1);
      compareVal("reset_tag", disp_tag, 8'h20);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = mk(1, OP_ADD, {8'h00, 32'd5}, {8'h00, 32'd7}, 0, 0, 1, 8'h20, 40'h0, "t2_disp");
`ifdef RS_BYPASS_EN
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, {8'h20, 32'h0000000C}, "t2_c1");
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "t2_c2");
`else
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, 40'h0, "t2_c1");
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, {8'h20, 32'h0000000C}, "t2_c2");
`endif
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "t2_free");
    tbl[4]  = mk(1, OP_MULTI, {8'h00, 32'd1}, {8'h00, 32'd2}, 0, 0, 1, 8'h20, 40'h0, "nonadd");
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "nonadd_c1");
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "nonadd_c2");
    tbl[7]  = mk(1, OP_ADD, {8'h30, 32'hDEAD}, {8'h00, 32'd1}, 0, 0, 1, 8'h20, 40'h0, "t3_disp");
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, 40'h0, "t3_wait");
    tbl[9]  = mk(0, 0, 0, 0, 0, {8'h30, 32'h34561234}, 1, 8'h21, 40'h0, "t3_mult");
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, 40'h0, "t3_issue");
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, {8'h20, 32'h34561235}, "t3_result");
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "t3_free");
    tbl[13] = mk(1, OP_ADD, {8'h30, 32'hDEAD}, {8'h00, 32'd1}, 0, {8'h30, 32'h34561234},
                 1, 8'h20, 40'h0, "t3b_disp");
`ifdef RS_BYPASS_EN
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, {8'h20, 32'h34561235}, "t3b_c1");
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "t3b_c2");
`else
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, 40'h0, "t3b_c1");
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 8'h21, {8'h20, 32'h34561235}, "t3b_c2");
`endif
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 8'h20, 40'h0, "t3b_free");

    rst_n = 1'b0;
    doReset();

    for (int k = 0; k < 17; k++) begin
      applyStimulus(tbl[k].dv, tbl[k].op, tbl[k].s1, tbl[k].s2, tbl[k].lb, tbl[k].mb);
      compareVal({tbl[k].name, "_ready"}, seen_ready, tbl[k].exp_ready);
      compareVal({tbl[k].name, "_tag"}, seen_tag, tbl[k].exp_tag);
      compareVal({tbl[k].name, "_addbus"}, seen_bus, tbl[k].exp_bus);
    end

    // Fill all three entries with ADDs waiting on M0, then release them together.
    res_cyc.delete(); res_val.delete();
    applyStimulus(1, OP_ADD, {8'h30, 32'h0}, {8'h00, 32'd1}, 0, 0);
    applyStimulus(1, OP_ADD, {8'h00, 32'd2}, {8'h30, 32'h0}, 0, 0);
    applyStimulus(1, OP_ADD, {8'h30, 32'h0}, {8'h30, 32'h0}, 0, 0);
    applyStimulus(1, OP_ADD, {8'h00, 32'd9}, {8'h00, 32'd9}, 0, 0);
    compareVal("full_ready", seen_ready, 1'b0);
    compareVal("full_tag", seen_tag, 8'h00);
    applyStimulus(0, 0, 0, 0, 0, {8'h30, 32'd100});
    idle(6);
    compareVal("order_count", res_val.size(), 3);
    if (res_val.size() >= 3) begin
      compareVal("order_a0", res_val[0], {8'h20, 32'd101});
      compareVal("order_a1", res_val[1], {8'h21, 32'd102});
      compareVal("order_a2", res_val[2], {8'h22, 32'd200});
      compareVal("order_consec", res_cyc[2] - res_cyc[0], 2);
    end

    // Wraparound sum on A1, and A2 chained on A1 through the station's own addbus.
    res_cyc.delete(); res_val.delete();
    applyStimulus(1, OP_ADD, {8'h40, 32'h0}, {8'h00, 32'h0}, 0, 0);
    applyStimulus(1, OP_ADD, {8'h00, 32'hFFFFFFFF}, {8'h00, 32'd2}, 0, 0);
    applyStimulus(1, OP_ADD, {8'h21, 32'hABC}, {8'h00, 32'h10}, 0, 0);
    idle(5);
    compareVal("chain_count", res_val.size(), 2);
    if (res_val.size() >= 2) begin
      compareVal("chain_wrap", res_val[0], {8'h21, 32'h00000001});
      compareVal("chain_a2", res_val[1], {8'h22, 32'h00000011});
    end
    applyStimulus(0, 0, 0, 0, {8'h40, 32'd5}, 0);
    idle(3);

    // Reset while an ADD is in flight must drop it.
    applyStimulus(1, OP_ADD, {8'h00, 32'd5}, {8'h00, 32'd7}, 0, 0);
    idle(1);
    doReset();
    res_cyc.delete(); res_val.delete();
    idle(4);
    compareVal("reset_no_broadcast", res_val.size(), 0);

    for (int n = 0; n < 400; n++) begin
      logic [39:0] lb, mb;
      lb = ($urandom_range(0, 1) == 1) ? {8'(8'h40 + $urandom_range(0, 1)), 32'($urandom)} : 40'h0;
      mb = ($urandom_range(0, 1) == 1) ? {8'(8'h30 + $urandom_range(0, 1)), 32'($urandom)} : 40'h0;
      applyStimulus(1'($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) < 8) ? OP_ADD : 8'($urandom_range(0, 4)),
                    rand_opnd(), rand_opnd(), lb, mb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
